keypad_scanner: RTL

Scans a 4x4 matrix keypad, debounces it and produces the decoded key value `dec` and the level signal `button_pressed`. It sits directly upstream of the game controller, which edge-detects `button_pressed` and samples `dec`. Columns are driven active-low one at a time. Rows are read back through a synchronizer, and each key is accepted only after it has been stable for a configurable number of full scans.

---
 rtl/keypad_scanner.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with per-scan debounce.
// Columns are driven active-low one at a time; rows are synchronized and
// sampled on the last tick of each column. A full-scan candidate must repeat
// DEBOUNCE_SCANS times before it changes dec / button_pressed.
// Optional build macro: KEYPAD_MULTI_REJECT_EN (multi-key scans read as no key).
module keypad_scanner #(
    parameter int SCAN_TICKS     = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] dec,
    output logic       button_pressed
);

    localparam int TW = $clog2(SCAN_TICKS);
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(SCAN_TICKS - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {COL0, COL1, COL2, COL3} col_state_e;
    typedef enum logic [1:0] {CAND_NONE, CAND_KEY, CAND_MULTI} cand_kind_e;

    col_state_e    state, state_next;
    logic [TW-1:0] tick;
    logic          last_tick;
    logic          end_of_scan;

    logic [3:0]    row_meta, row_sync;

    logic [1:0]    acc_cnt, scan_cnt;
    logic [3:0]    acc_code, scan_code;

    cand_kind_e    cand_kind, prev_kind;
    logic [3:0]    cand_code, prev_code;
    logic [SW-1:0] stable_cnt, stable_next;
    logic          cand_same;
    logic          accept_now, accept_q;
    logic          reassert;

    assign last_tick   = (tick == TICK_LAST);
    assign end_of_scan = last_tick && (state == COL3);

    // Key value at (row r, column c), c0 leftmost.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_code = 4'h1;
            4'h1: key_code = 4'h2;
            4'h2: key_code = 4'h3;
            4'h3: key_code = 4'hA;
            4'h4: key_code = 4'h4;
            4'h5: key_code = 4'h5;
            4'h6: key_code = 4'h6;
            4'h7: key_code = 4'hB;
            4'h8: key_code = 4'h7;
            4'h9: key_code = 4'h8;
            4'hA: key_code = 4'h9;
            4'hB: key_code = 4'hC;
            4'hC: key_code = 4'h0;
            4'hD: key_code = 4'hF;
            4'hE: key_code = 4'hE;
            default: key_code = 4'hD;
        endcase
    endfunction

    // Two-flop synchronizer for the asynchronous row inputs (idle = released).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // Column FSM state register and per-column tick counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= COL0;
            tick  <= '0;
        end else begin
            state <= state_next;
            tick  <= last_tick ? '0 : tick + TW'(1);
        end
    end

    // Column FSM next state: advance one column after its last tick.
    always_comb begin
        state_next = state;
        if (last_tick) begin
            case (state)
                COL0:    state_next = COL1;
                COL1:    state_next = COL2;
                COL2:    state_next = COL3;
                default: state_next = COL0;
            endcase
        end
    end

    // Column FSM output: exactly one column driven low.
    always_comb begin
        col = ~(4'b0001 << state);
    end

    // Fold this column's row hits into the running scan result (first hit wins).
    always_comb begin
        scan_cnt  = acc_cnt;
        scan_code = acc_code;
        for (int unsigned r = 0; r < 4; r++) begin
            if (!row_sync[r]) begin
                if (scan_cnt == 2'd0) scan_code = key_code(r[1:0], state);
                if (scan_cnt != 2'd2) scan_cnt = scan_cnt + 2'd1;
            end
        end
    end

    // Candidate for the finished scan and the debounce counter update.
    always_comb begin
        cand_kind = CAND_NONE;
        if (scan_cnt == 2'd1) begin
            cand_kind = CAND_KEY;
        end else if (scan_cnt == 2'd2) begin
`ifdef KEYPAD_MULTI_REJECT_EN
            cand_kind = CAND_MULTI;
`else
            cand_kind = CAND_KEY;
`endif
        end
        cand_code = (cand_kind == CAND_KEY) ? scan_code : '0;
        cand_same = (cand_kind == prev_kind) && (cand_code == prev_code);
        if (!cand_same)                 stable_next = SW'(1);
        else if (stable_cnt == STABLE_MAX) stable_next = STABLE_MAX;
        else                            stable_next = stable_cnt + SW'(1);
        // Accept only on the scan where the count first reaches the threshold.
        accept_now = (stable_next == STABLE_MAX) && !(cand_same && stable_cnt == STABLE_MAX);
    end

    // Per-scan accumulator and debounce history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_cnt    <= '0;
            acc_code   <= '0;
            prev_kind  <= CAND_NONE;
            prev_code  <= '0;
            stable_cnt <= '0;
            accept_q   <= 1'b0;
        end else begin
            accept_q <= end_of_scan && accept_now;
            if (end_of_scan) begin
                acc_cnt    <= '0;
                acc_code   <= '0;
                prev_kind  <= cand_kind;
                prev_code  <= cand_code;
                stable_cnt <= stable_next;
            end else if (last_tick) begin
                acc_cnt  <= scan_cnt;
                acc_code <= scan_code;
            end
        end
    end

    // Output update one cycle after acceptance; a key change while pressed
    // drops button_pressed for one cycle so downstream sees a fresh edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec            <= '0;
            button_pressed <= 1'b0;
            reassert       <= 1'b0;
        end else if (accept_q) begin
            reassert <= 1'b0;
            if (prev_kind == CAND_KEY) begin
                if (!button_pressed) begin
                    dec            <= prev_code;
                    button_pressed <= 1'b1;
                end else if (prev_code != dec) begin
                    dec            <= prev_code;
                    button_pressed <= 1'b0;
                    reassert       <= 1'b1;
                end
            end else begin
                button_pressed <= 1'b0;
            end
        end else if (reassert) begin
            button_pressed <= 1'b1;
            reassert       <= 1'b0;
        end
    end

endmodule
